// File: rtl/lead_one_finder.sv
// lead_one_finder: two-stage pipeline that turns a signed mantissa sum into
// sign + magnitude, finds the index of the magnitude's leading one and passes
// the exponent through. Valid/ready on both sides; back-pressure stalls both
// stages in place (no skid buffer, in_ready is combinational from out_ready).
//
// Stage 1 registers the absolute value plus a per-group summary
// (group non-zero flag and in-group leading-one offset). Stage 2 picks the
// highest non-zero group and combines it with that group's offset.
//
// Optional build macro: LOF_ZERO_FLUSH_EN
//   defined   - a zero-magnitude beat leaves with exp_max = 0 and out_sign = 0
//   undefined - zero beats keep their exponent and sign; only out_zero flags them
module lead_one_finder #(
    parameter int MANT_W = 50,
    parameter int POS_W  = 6,
    parameter int EXP_W  = 8,
    parameter int GRP_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [MANT_W-1:0] unsign_mant,
    output logic [POS_W-1:0]  leading_pos,
    output logic [EXP_W-1:0]  exp_max,
    output logic              out_zero
);

    localparam int NGRP  = MANT_W / GRP_W;
    localparam int OFF_W = (GRP_W > 1) ? $clog2(GRP_W) : 1;

    logic                       v1;
    logic                       v2;
    logic                       s1_load;
    logic                       s2_load;

    logic [MANT_W-1:0]          mag_c;
    logic [NGRP-1:0]            nz_c;
    logic [NGRP-1:0][OFF_W-1:0] off_c;

    logic                       sign_r;
    logic [MANT_W-1:0]          mag_r;
    logic [EXP_W-1:0]           exp_r;
    logic [NGRP-1:0]            nz_r;
    logic [NGRP-1:0][OFF_W-1:0] off_r;

    logic [POS_W-1:0]           lp_c;
    logic                       zero_c;
    logic                       sign_c;
    logic [EXP_W-1:0]           exp_c;

    // Each stage advances when it is empty or the stage after it is moving.
    assign s2_load   = !v2 || out_ready;
    assign s1_load   = !v1 || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = v2;

    // Absolute value (the most negative input wraps to itself, which is the
    // correct unsigned magnitude) and the per-group leading-one summary.
    always_comb begin
        mag_c = in_mant[MANT_W-1] ? (~in_mant + MANT_W'(1)) : in_mant;
        nz_c  = '0;
        off_c = '0;
        for (int g = 0; g < NGRP; g++) begin
            nz_c[g] = |mag_c[g*GRP_W +: GRP_W];
            for (int i = 0; i < GRP_W; i++) begin
                if (mag_c[g*GRP_W + i]) begin
                    off_c[g] = OFF_W'(i);
                end
            end
        end
    end

    // Stage 1 register: valid bit follows the input handshake, data only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            sign_r <= 1'b0;
            mag_r  <= '0;
            exp_r  <= '0;
            nz_r   <= '0;
            off_r  <= '0;
        end else if (s1_load) begin
            v1 <= in_valid;
            if (in_valid) begin
                sign_r <= in_mant[MANT_W-1];
                mag_r  <= mag_c;
                exp_r  <= in_exp;
                nz_r   <= nz_c;
                off_r  <= off_c;
            end
        end
    end

    // Highest non-zero group wins; ascending scan so later hits override.
    always_comb begin
        lp_c   = '0;
        zero_c = 1'b1;
        for (int g = 0; g < NGRP; g++) begin
            if (nz_r[g]) begin
                lp_c   = POS_W'(g*GRP_W) + POS_W'(off_r[g]);
                zero_c = 1'b0;
            end
        end
    end

`ifdef LOF_ZERO_FLUSH_EN
    // A zero result always leaves as +0 with a cleared exponent.
    assign sign_c = sign_r & ~zero_c;
    assign exp_c  = zero_c ? '0 : exp_r;
`else
    assign sign_c = sign_r;
    assign exp_c  = exp_r;
`endif

    // Stage 2 register: drives the outputs directly; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2          <= 1'b0;
            out_sign    <= 1'b0;
            unsign_mant <= '0;
            leading_pos <= '0;
            exp_max     <= '0;
            out_zero    <= 1'b0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                out_sign    <= sign_c;
                unsign_mant <= mag_r;
                leading_pos <= lp_c;
                exp_max     <= exp_c;
                out_zero    <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_lead_one_finder.sv
// Testbench for lead_one_finder: directed steps, scoreboard of expected beats
// pushed on input handshake and checked on output handshake.
module tb_lead_one_finder;

    localparam int MW = 50;
    localparam int PW = 6;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_mant = '0;
    logic [EW-1:0] in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sign;
    logic [MW-1:0] unsign_mant;
    logic [PW-1:0] leading_pos;
    logic [EW-1:0] exp_max;
    logic          out_zero;

    int errors = 0;
    int checks = 0;
    int popped = 0;

    typedef struct {
        logic          sign;
        logic [MW-1:0] mag;
        logic [PW-1:0] lp;
        logic [EW-1:0] ex;
        logic          zero;
    } beat_t;

    beat_t sb[$];

    lead_one_finder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .unsign_mant(unsign_mant),
        .leading_pos(leading_pos), .exp_max(exp_max),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t model(input logic [MW-1:0] m, input logic [EW-1:0] e);
        beat_t r;
        r.sign = m[MW-1];
        r.mag  = m[MW-1] ? (MW'(0) - m) : m;
        r.lp   = '0;
        for (int i = 0; i < MW; i++) if (r.mag[i]) r.lp = PW'(i);
        r.zero = (r.mag == '0);
        r.ex   = e;
`ifdef LOF_ZERO_FLUSH_EN
        if (r.zero) begin
            r.ex   = '0;
            r.sign = 1'b0;
        end
`endif
        return r;
    endfunction

    // Handshakes complete on the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back(model(in_mant, in_exp));
            if (out_valid && out_ready) begin
                chk("unexpected_beat", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    popped++;
                    chk("leading_pos", 64'(leading_pos), 64'(e.lp));
                    chk("unsign_mant", 64'(unsign_mant), 64'(e.mag));
                    chk("out_sign",    64'(out_sign),    64'(e.sign));
                    chk("exp_max",     64'(exp_max),     64'(e.ex));
                    chk("out_zero",    64'(out_zero),    64'(e.zero));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted; leaves in_valid high.
    task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e);
        logic hs;
        int n;
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            n++;
        end
        if (!hs) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_mant  = '0;
        in_exp   = '0;
    endtask

    // Single beat with the 2-cycle latency checked around it.
    task automatic send_one(input logic [MW-1:0] m, input logic [EW-1:0] e);
        send(m, e);
        idle();
        chk("lat_early", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [MW-1:0] lead_at(input int b);
        logic [MW-1:0] one;
        logic [MW-1:0] r;
        one = MW'(1);
        r   = MW'({$urandom, $urandom});
        return (one << b) | (r & ((one << b) - one));
    endfunction

    initial begin
        int lead_bits[8] = '{0, 4, 5, 9, 10, 25, 44, 48};
        int p0;
        logic [MW-1:0] sb_a;

        // Reset state
        #3;
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_in_ready",    64'(in_ready),    64'd1);
        chk("rst_unsign_mant", 64'(unsign_mant), 64'd0);
        chk("rst_leading_pos", 64'(leading_pos), 64'd0);
        chk("rst_exp_max",     64'(exp_max),     64'd0);
        chk("rst_out_sign",    64'(out_sign),    64'd0);
        chk("rst_out_zero",    64'(out_zero),    64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // +1
        send_one(MW'(1), 8'h7F);
        chk("one_lp",  64'(leading_pos), 64'd0);
        chk("one_mag", 64'(unsign_mant), 64'd1);
        chk("one_exp", 64'(exp_max),     64'h7F);
        drain();

        // -3
        send_one(50'h3_FFFF_FFFF_FFFD, 8'h80);
        chk("neg3_sign", 64'(out_sign),    64'd1);
        chk("neg3_mag",  64'(unsign_mant), 64'd3);
        chk("neg3_lp",   64'(leading_pos), 64'd1);
        drain();

        // Most negative input
        send_one(50'h2_0000_0000_0000, 8'h10);
        chk("mneg_sign", 64'(out_sign),    64'd1);
        chk("mneg_mag",  64'(unsign_mant), 64'h2_0000_0000_0000);
        chk("mneg_lp",   64'(leading_pos), 64'd49);
        drain();

        // Zero
        send_one('0, 8'h55);
        chk("zero_flag", 64'(out_zero),    64'd1);
        chk("zero_lp",   64'(leading_pos), 64'd0);
`ifdef LOF_ZERO_FLUSH_EN
        chk("zero_exp",  64'(exp_max),     64'h00);
`else
        chk("zero_exp",  64'(exp_max),     64'h55);
`endif
        drain();

        // Streaming with a 4-cycle output stall
        p0 = popped;
        fork
            begin
                foreach (lead_bits[k]) send(lead_at(lead_bits[k]), EW'(8'h20 + k));
                idle();
            end
            begin
                tick();
                tick();
                out_ready = 1'b0;
                tick();
                tick();
                chk("stall_in_ready",  64'(in_ready),  64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                sb_a = unsign_mant;
                tick();
                chk("stall_hold", 64'(unsign_mant), 64'(sb_a));
                tick();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 64'(popped - p0), 64'd8);

        // Negative values mid-range
        send(MW'(0) - lead_at(17), 8'hA1);
        send(MW'(0) - lead_at(30), 8'hA2);
        idle();
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(lead_at(12), 8'h31);
        send(lead_at(40), 8'h32);
        idle();
        chk("full_in_ready",  64'(in_ready),  64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid",   64'(out_valid),   64'd0);
        chk("arst_in_ready",    64'(in_ready),    64'd1);
        chk("arst_unsign_mant", 64'(unsign_mant), 64'd0);
        chk("arst_exp_max",     64'(exp_max),     64'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arst_no_beat", 64'(out_valid), 64'd0);
        send_one(lead_at(33), 8'h44);
        chk("arst_new_lp", 64'(leading_pos), 64'd33);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
